// File: rtl/switch_event_capture_pkg.sv
// Shared types and default sizing for the switch event capture block.
package switch_event_capture_pkg;

  localparam int DEF_NUM_SW       = 18;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int IDX_W            = 5;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             level;
  } sw_event_t;

endpackage

// File: rtl/switch_event_capture_event_fifo.sv
// Registered event queue; pointers carry one extra wrap bit to tell full from empty.
module event_fifo
  import switch_event_capture_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  sw_event_t        push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output sw_event_t        head,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  sw_event_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so stale storage never reaches the outputs.
  assign head = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/switch_event_capture.sv
// Debounces slide switches on a slow tick and queues one event per stable change.
module switch_event_capture
  import switch_event_capture_pkg::*;
#(
  parameter int NUM_SW       = DEF_NUM_SW,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic              CLOCK_50_I,
  input  logic              RESET_I,
  input  logic [NUM_SW-1:0] SWITCH_I,
  output logic [NUM_SW-1:0] SWITCH_STABLE_O,
  output logic              EVENT_VALID_O,
  input  logic              EVENT_READY_I,
  output logic [4:0]        EVENT_INDEX_O,
  output logic              EVENT_LEVEL_O,
  output logic [2:0]        EVENT_COUNT_O
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = $clog2(STABLE_TICKS + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SW-1:0] sw_p0, sw_p1;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [NUM_SW-1:0] stable, stable_nxt;
  logic [CW-1:0]     db_cnt  [NUM_SW];
  logic [CW-1:0]     cnt_nxt [NUM_SW];
  logic [NUM_SW-1:0] pending, pend_set, grant_oh;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_lvl;
  logic              push, fifo_full, fifo_valid;
  sw_event_t         head;
  logic [FCW-1:0]    fifo_count;

  // Stage p0/p1: two-flop synchronizer on the raw switch levels
  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= SWITCH_I;
      sw_p1 <= sw_p0;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  always_comb begin
    stable_nxt = stable;
    pend_set   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_nxt[i] = db_cnt[i];
      if (tick) begin
        if (sw_p1[i] != stable[i]) begin
          if (db_cnt[i] == CW'(STABLE_TICKS - 1)) begin
            stable_nxt[i] = ~stable[i];
            cnt_nxt[i]    = '0;
            pend_set[i]   = 1'b1;
          end else begin
            cnt_nxt[i] = db_cnt[i] + 1'b1;
          end
        end else begin
          cnt_nxt[i] = '0;
        end
      end
    end
  end

  // Lowest index wins; the level is read at push time so repeated toggles collapse.
  always_comb begin
    grant_idx = '0;
    grant_lvl = 1'b0;
    grant_oh  = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx   = IDX_W'(i);
        grant_lvl   = stable[i];
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign push = (|pending) && (!fifo_full || (fifo_valid && EVENT_READY_I));

  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      stable  <= '0;
      pending <= '0;
      for (int i = 0; i < NUM_SW; i++) db_cnt[i] <= '0;
    end else begin
      stable  <= stable_nxt;
      pending <= (pending & ~(push ? grant_oh : '0)) | pend_set;
      for (int i = 0; i < NUM_SW; i++) db_cnt[i] <= cnt_nxt[i];
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FCW)
  ) u_fifo (
    .clk       (CLOCK_50_I),
    .rst       (RESET_I),
    .push      (push),
    .push_data ('{index: grant_idx, level: grant_lvl}),
    .pop       (EVENT_READY_I),
    .full      (fifo_full),
    .valid     (fifo_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign SWITCH_STABLE_O = stable;
  assign EVENT_VALID_O   = fifo_valid;
  assign EVENT_INDEX_O   = head.index;
  assign EVENT_LEVEL_O   = head.level;
  assign EVENT_COUNT_O   = 3'(fifo_count);

endmodule
